// File: rtl/axi_ram_pkg.sv
// axi_ram_pkg: shared types and constants for the axi_burst_ram slice.
//   burst_t     - AXI burst encodings (2'b11 is unsupported and handled by the RAM)
//   RESP_*      - AXI response codes used on bresp/rresp
//   wr_state_t  - write channel FSM states
//   rd_state_t  - read channel FSM states
//   clamp_size  - limits AxSIZE to the data bus width
package axi_ram_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10
    } burst_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

    // A transfer can never be wider than the bus, so larger sizes collapse to it.
    function automatic logic [2:0] clamp_size(input logic [2:0] size, input int unsigned asb);
        logic [2:0] lim;
        lim = 3'(asb);
        return (size > lim) ? lim : size;
    endfunction

endpackage

// File: rtl/axi_if.sv
// axi_if: AXI3/AXI4 bus bundle (no clock/reset inside; those stay scalar ports).
// Parameters: AWIDTH address width, DWIDTH data width (32/64), IWIDTH id width,
//             AXI3 selects a 4-bit AxLEN (1) or 8-bit AxLEN (0).
// Modports:   master drives AW/W/AR and bready/rready; slave drives the rest.
// Handshake:  every channel transfers on a rising clock edge where valid and ready
//             are both high; a source holds valid and its payload stable until then,
//             and must not wait for ready before raising valid.
interface axi_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32,
    parameter int IWIDTH = 1,
    parameter int AXI3   = 0
);
    localparam int LW   = (AXI3 != 0) ? 4 : 8;
    localparam int STRB = DWIDTH / 8;

    logic [IWIDTH-1:0] awid;
    logic [AWIDTH-1:0] awaddr;
    logic [LW-1:0]     awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awvalid;
    logic              awready;

    logic [DWIDTH-1:0] wdata;
    logic [STRB-1:0]   wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;

    logic [IWIDTH-1:0] bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    logic [IWIDTH-1:0] arid;
    logic [AWIDTH-1:0] araddr;
    logic [LW-1:0]     arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;

    logic [IWIDTH-1:0] rid;
    logic [DWIDTH-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/axi_ram_addr_gen.sv
// axi_ram_addr_gen: combinational AXI next-beat address.
// Ports: addr  - address of the current beat
//        len   - AxLEN, zero-extended to 8 bits
//        size  - AxSIZE (clamped to the bus width internally)
//        burst - AxBURST; 2'b11 behaves as INCR
//        next  - address of the following beat
module axi_ram_addr_gen
    import axi_ram_pkg::*;
#(
    parameter int          AWIDTH = 32,
    parameter int unsigned ASB    = 2
) (
    input  logic [AWIDTH-1:0] addr,
    input  logic [7:0]        len,
    input  logic [2:0]        size,
    input  logic [1:0]        burst,
    output logic [AWIDTH-1:0] next
);
    logic [2:0]        esize;
    logic [AWIDTH-1:0] step;
    logic [AWIDTH-1:0] aligned;
    logic [AWIDTH-1:0] wmask;

    always_comb begin
        esize   = clamp_size(size, ASB);
        step    = AWIDTH'(1) << esize;
        // Only the first INCR beat may be unaligned; later beats snap to size.
        aligned = addr & ~(step - AWIDTH'(1));
        // WRAP window is (len+1) transfers wide and aligned to its own size.
        wmask   = ((AWIDTH'(len) + AWIDTH'(1)) << esize) - AWIDTH'(1);
        next    = aligned + step;
        case (burst_t'(burst))
            FIXED:   next = addr;
            WRAP:    next = (aligned & ~wmask) | ((aligned + step) & wmask);
            default: next = aligned + step;
        endcase
    end

endmodule

// File: rtl/axi_burst_ram.sv
// axi_burst_ram: burst-capable AXI3/AXI4 slave memory.
// Ports: aclk    - clock; all bus outputs are registered on its rising edge
//        aresetn - asynchronous active-low reset (array contents survive it)
//        s_axi   - axi_if.slave bus port
//        busy    - high while the write or read channel is mid-transaction
// Build option: define AXI_RAM_ERR_EN to flag out-of-range beats, wlast/beat
// count disagreement and burst type 2'b11 with SLVERR; otherwise addresses alias
// modulo DEPTH and responses are always OKAY.
module axi_burst_ram
    import axi_ram_pkg::*;
#(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32,
    parameter int IWIDTH = 1,
    parameter int AXI3   = 0,
    parameter int DEPTH  = 1024
) (
    input  logic  aclk,
    input  logic  aresetn,
    axi_if.slave  s_axi,
    output logic  busy
);
    localparam int STRB = DWIDTH / 8;
    localparam int ASB  = $clog2(STRB);
    localparam int IDXW = $clog2(DEPTH);

    logic [DWIDTH-1:0] mem [DEPTH];

    // ---------------- write channel ----------------
    wr_state_t         wr_state, wr_state_n;
    logic [AWIDTH-1:0] wr_addr, wr_addr_n, wr_next;
    logic [7:0]        wr_len, wr_len_n, wr_cnt, wr_cnt_n;
    logic [2:0]        wr_size, wr_size_n;
    logic [1:0]        wr_burst, wr_burst_n;
    logic              wr_err, wr_err_n;
    logic              awready_n, wready_n, bvalid_n;
    logic [IWIDTH-1:0] bid_n;
    logic [1:0]        bresp_n;
    logic              w_beat, w_bad, w_last_bad, mem_we;
    logic [IDXW-1:0]   wr_idx;

    // ---------------- read channel ----------------
    rd_state_t         rd_state, rd_state_n;
    logic [AWIDTH-1:0] rd_addr, rd_addr_n, rd_next;
    logic [7:0]        rd_len, rd_len_n, rd_cnt, rd_cnt_n;
    logic [2:0]        rd_size, rd_size_n;
    logic [1:0]        rd_burst, rd_burst_n;
    logic              arready_n, rvalid_n, rlast_n;
    logic [IWIDTH-1:0] rid_n;
    logic [1:0]        rresp_n;
    logic              rd_fetch, r_bad;
    // Address/params of the beat being fetched: the AR payload while idle,
    // otherwise the stored next-beat address.
    logic [AWIDTH-1:0] rg_addr;
    logic [7:0]        rg_len;
    logic [2:0]        rg_size;
    logic [1:0]        rg_burst;
    logic [IDXW-1:0]   rd_idx;

    assign wr_idx = wr_addr[ASB+IDXW-1:ASB];
    assign rd_idx = rg_addr[ASB+IDXW-1:ASB];

    always_comb begin
        if (rd_state == R_IDLE) begin
            rg_addr  = s_axi.araddr;
            rg_len   = 8'(s_axi.arlen);
            rg_size  = s_axi.arsize;
            rg_burst = s_axi.arburst;
        end else begin
            rg_addr  = rd_addr;
            rg_len   = rd_len;
            rg_size  = rd_size;
            rg_burst = rd_burst;
        end
    end

`ifdef AXI_RAM_ERR_EN
    function automatic logic out_of_range(input logic [AWIDTH-1:0] a);
        return |(a >> (ASB + IDXW));
    endfunction

    assign w_bad      = out_of_range(wr_addr) || (wr_burst == 2'b11);
    assign w_last_bad = s_axi.wlast != (wr_cnt == wr_len);
    assign r_bad      = out_of_range(rg_addr) || (rg_burst == 2'b11);
`else
    assign w_bad      = 1'b0;
    assign w_last_bad = 1'b0;
    assign r_bad      = 1'b0;
`endif

    axi_ram_addr_gen #(.AWIDTH(AWIDTH), .ASB(ASB)) u_wr_gen (
        .addr  (wr_addr),
        .len   (wr_len),
        .size  (wr_size),
        .burst (wr_burst),
        .next  (wr_next)
    );

    axi_ram_addr_gen #(.AWIDTH(AWIDTH), .ASB(ASB)) u_rd_gen (
        .addr  (rg_addr),
        .len   (rg_len),
        .size  (rg_size),
        .burst (rg_burst),
        .next  (rd_next)
    );

    // Write FSM: next state and next registered outputs.
    always_comb begin
        wr_state_n = wr_state;
        wr_addr_n  = wr_addr;
        wr_len_n   = wr_len;
        wr_cnt_n   = wr_cnt;
        wr_size_n  = wr_size;
        wr_burst_n = wr_burst;
        wr_err_n   = wr_err;
        awready_n  = s_axi.awready;
        wready_n   = s_axi.wready;
        bvalid_n   = s_axi.bvalid;
        bid_n      = s_axi.bid;
        bresp_n    = s_axi.bresp;
        mem_we     = 1'b0;
        w_beat     = s_axi.wvalid && s_axi.wready;
        case (wr_state)
            W_IDLE: begin
                awready_n = 1'b1;
                if (s_axi.awvalid && s_axi.awready) begin
                    awready_n  = 1'b0;
                    wready_n   = 1'b1;
                    wr_addr_n  = s_axi.awaddr;
                    wr_len_n   = 8'(s_axi.awlen);
                    wr_size_n  = s_axi.awsize;
                    wr_burst_n = s_axi.awburst;
                    wr_cnt_n   = '0;
                    wr_err_n   = 1'b0;
                    bid_n      = s_axi.awid;
                    wr_state_n = W_DATA;
                end
            end
            W_DATA: begin
                if (w_beat) begin
                    mem_we    = !w_bad;
                    wr_err_n  = wr_err || w_bad || w_last_bad;
                    wr_addr_n = wr_next;
                    wr_cnt_n  = wr_cnt + 8'd1;
                    // The beat count, not wlast, closes the burst.
                    if (wr_cnt == wr_len) begin
                        wready_n   = 1'b0;
                        bvalid_n   = 1'b1;
                        bresp_n    = wr_err_n ? RESP_SLVERR : RESP_OKAY;
                        wr_state_n = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (s_axi.bvalid && s_axi.bready) begin
                    bvalid_n   = 1'b0;
                    awready_n  = 1'b1;
                    wr_state_n = W_IDLE;
                end
            end
            default: wr_state_n = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_state      <= W_IDLE;
            wr_addr       <= '0;
            wr_len        <= '0;
            wr_cnt        <= '0;
            wr_size       <= '0;
            wr_burst      <= '0;
            wr_err        <= 1'b0;
            s_axi.awready <= 1'b0;
            s_axi.wready  <= 1'b0;
            s_axi.bvalid  <= 1'b0;
            s_axi.bid     <= '0;
            s_axi.bresp   <= '0;
        end else begin
            wr_state      <= wr_state_n;
            wr_addr       <= wr_addr_n;
            wr_len        <= wr_len_n;
            wr_cnt        <= wr_cnt_n;
            wr_size       <= wr_size_n;
            wr_burst      <= wr_burst_n;
            wr_err        <= wr_err_n;
            s_axi.awready <= awready_n;
            s_axi.wready  <= wready_n;
            s_axi.bvalid  <= bvalid_n;
            s_axi.bid     <= bid_n;
            s_axi.bresp   <= bresp_n;
        end
    end

    // Read FSM: the AR handshake fetches beat 0 so rvalid rises the next cycle;
    // each accepted non-last beat fetches the following one.
    always_comb begin
        rd_state_n = rd_state;
        rd_addr_n  = rd_addr;
        rd_len_n   = rd_len;
        rd_cnt_n   = rd_cnt;
        rd_size_n  = rd_size;
        rd_burst_n = rd_burst;
        arready_n  = s_axi.arready;
        rvalid_n   = s_axi.rvalid;
        rlast_n    = s_axi.rlast;
        rid_n      = s_axi.rid;
        rresp_n    = s_axi.rresp;
        rd_fetch   = 1'b0;
        case (rd_state)
            R_IDLE: begin
                arready_n = 1'b1;
                if (s_axi.arvalid && s_axi.arready) begin
                    arready_n  = 1'b0;
                    rvalid_n   = 1'b1;
                    rlast_n    = (s_axi.arlen == '0);
                    rid_n      = s_axi.arid;
                    rd_len_n   = 8'(s_axi.arlen);
                    rd_size_n  = s_axi.arsize;
                    rd_burst_n = s_axi.arburst;
                    rd_addr_n  = rd_next;
                    rd_cnt_n   = '0;
                    rd_fetch   = 1'b1;
                    rresp_n    = r_bad ? RESP_SLVERR : RESP_OKAY;
                    rd_state_n = R_DATA;
                end
            end
            R_DATA: begin
                if (s_axi.rvalid && s_axi.rready) begin
                    if (s_axi.rlast) begin
                        rvalid_n   = 1'b0;
                        rlast_n    = 1'b0;
                        arready_n  = 1'b1;
                        rd_state_n = R_IDLE;
                    end else begin
                        rd_fetch  = 1'b1;
                        rd_addr_n = rd_next;
                        rd_cnt_n  = rd_cnt + 8'd1;
                        rlast_n   = (rd_cnt_n == rd_len);
                        // Once a burst has errored, it keeps reporting SLVERR.
                        rresp_n   = ((s_axi.rresp == RESP_SLVERR) || r_bad) ? RESP_SLVERR : RESP_OKAY;
                    end
                end
            end
            default: rd_state_n = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_state      <= R_IDLE;
            rd_addr       <= '0;
            rd_len        <= '0;
            rd_cnt        <= '0;
            rd_size       <= '0;
            rd_burst      <= '0;
            s_axi.arready <= 1'b0;
            s_axi.rvalid  <= 1'b0;
            s_axi.rlast   <= 1'b0;
            s_axi.rid     <= '0;
            s_axi.rresp   <= '0;
        end else begin
            rd_state      <= rd_state_n;
            rd_addr       <= rd_addr_n;
            rd_len        <= rd_len_n;
            rd_cnt        <= rd_cnt_n;
            rd_size       <= rd_size_n;
            rd_burst      <= rd_burst_n;
            s_axi.arready <= arready_n;
            s_axi.rvalid  <= rvalid_n;
            s_axi.rlast   <= rlast_n;
            s_axi.rid     <= rid_n;
            s_axi.rresp   <= rresp_n;
        end
    end

    // Registered read port; a same-cycle write to the word is seen next time.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s_axi.rdata <= '0;
        end else if (rd_fetch) begin
            s_axi.rdata <= r_bad ? '0 : mem[rd_idx];
        end
    end

    // Write port with per-byte strobes; no reset so contents survive aresetn.
    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int b = 0; b < STRB; b++) begin
                if (s_axi.wstrb[b]) begin
                    mem[wr_idx][8*b +: 8] <= s_axi.wdata[8*b +: 8];
                end
            end
        end
    end

    assign busy = (wr_state != W_IDLE) || (rd_state != R_IDLE);

endmodule

// File: tb/tb_axi_burst_ram.sv
// tb_axi_burst_ram: self-checking bench for axi_burst_ram.
// Directed bursts (INCR/WRAP/FIXED, strobes, rready stalls, reset mid-burst)
// followed by randomized bursts, all checked against a byte-lane word model
// whose beat addresses come straight from the AXI burst address rules.
module tb_axi_burst_ram;
    import axi_ram_pkg::*;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int IW    = 2;
    localparam int DEPTH = 1024;
    localparam int STRB  = DW / 8;
    localparam int TMO   = 300;

    // ---------------- clock / reset ----------------
    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    logic busy;
    always #5 aclk = ~aclk;

    axi_if #(.AWIDTH(AW), .DWIDTH(DW), .IWIDTH(IW), .AXI3(0)) ax ();

    axi_burst_ram #(
        .AWIDTH(AW), .DWIDTH(DW), .IWIDTH(IW), .AXI3(0), .DEPTH(DEPTH)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s_axi   (ax),
        .busy    (busy)
    );

    // ---------------- scoreboard state ----------------
    int              checks = 0;
    int              errors = 0;
    logic [DW-1:0]   ref_mem [DEPTH];
    logic [DW-1:0]   exp_q[$];
    logic [DW-1:0]   wd [256];
    logic [STRB-1:0] ws [256];
    logic [DW-1:0]   last_rdata;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int unsigned beat_addr(input int unsigned start, input int len,
                                              input int size, input int burst, input int i);
        int unsigned nb    = 32'd1 << size;
        int unsigned al    = (start / nb) * nb;
        int unsigned win   = nb * (len + 1);
        int unsigned lower = (start / win) * win;
        if (burst == 0) return start;
        if (burst == 2) return lower + ((al - lower + i * nb) % win);
        return (i == 0) ? start : al + i * nb;
    endfunction

    function automatic bit in_range(input int unsigned a);
        return (a / STRB) < DEPTH;
    endfunction

    task automatic model_wr(input int unsigned a, input logic [DW-1:0] d, input logic [STRB-1:0] s);
        int idx = int'((a / STRB) % DEPTH);
`ifdef AXI_RAM_ERR_EN
        if (!in_range(a)) return;
`endif
        for (int b = 0; b < STRB; b++)
            if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
    endtask

    function automatic logic [DW-1:0] model_rd(input int unsigned a);
`ifdef AXI_RAM_ERR_EN
        if (!in_range(a)) return '0;
`endif
        return ref_mem[int'((a / STRB) % DEPTH)];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle_bus();
        ax.awvalid = 0; ax.wvalid = 0; ax.wlast = 0; ax.bready = 0;
        ax.arvalid = 0; ax.rready = 0;
        ax.awid = '0; ax.awaddr = '0; ax.awlen = '0; ax.awsize = '0; ax.awburst = '0;
        ax.wdata = '0; ax.wstrb = '0;
        ax.arid = '0; ax.araddr = '0; ax.arlen = '0; ax.arsize = '0; ax.arburst = '0;
    endtask

    // Writes wd/ws[0..len]; abort_after>=0 stops after that many accepted beats.
    task automatic axi_write(input int unsigned addr, input int len, input int size, input int burst,
                             input logic [IW-1:0] id, input int abort_after, input logic [1:0] exp_resp);
        int n;
        ax.awaddr = addr; ax.awlen = 8'(len); ax.awsize = 3'(size); ax.awburst = 2'(burst);
        ax.awid = id; ax.awvalid = 1;
        n = 0;
        while (n < TMO) begin @(negedge aclk); if (ax.awready) break; n++; end
        if (n >= TMO) begin check("aw_timeout", 0, 1); ax.awvalid = 0; return; end
        @(posedge aclk); #1;
        ax.awvalid = 0;
        for (int i = 0; i <= len; i++) begin
            if (abort_after >= 0 && i == abort_after) begin ax.wvalid = 0; return; end
            if ($urandom_range(0, 3) == 0) begin
                ax.wvalid = 0;
                repeat ($urandom_range(1, 2)) @(posedge aclk);
                #1;
            end
            ax.wdata = wd[i]; ax.wstrb = ws[i]; ax.wlast = (i == len); ax.wvalid = 1;
            n = 0;
            while (n < TMO) begin @(negedge aclk); if (ax.wready) break; n++; end
            if (n >= TMO) begin check("w_timeout", 0, 1); ax.wvalid = 0; return; end
            @(posedge aclk); #1;
            model_wr(beat_addr(addr, len, size, burst, i), wd[i], ws[i]);
        end
        ax.wvalid = 0; ax.wlast = 0;
        check("bvalid_latency", ax.bvalid, 1);
        repeat ($urandom_range(0, 2)) begin
            @(posedge aclk); #1;
            check("bvalid_hold", ax.bvalid, 1);
        end
        ax.bready = 1;
        n = 0;
        while (n < TMO) begin @(negedge aclk); if (ax.bvalid) break; n++; end
        if (n >= TMO) begin check("b_timeout", 0, 1); ax.bready = 0; return; end
        check("bid", ax.bid, id);
        check("bresp", ax.bresp, exp_resp);
        @(posedge aclk); #1;
        ax.bready = 0;
        check("awready_after_b", ax.awready, 1);
    endtask

    task automatic ar_issue(input int unsigned addr, input int len, input int size, input int burst,
                            input logic [IW-1:0] id, output bit ok);
        int n;
        ok = 0;
        ax.araddr = addr; ax.arlen = 8'(len); ax.arsize = 3'(size); ax.arburst = 2'(burst);
        ax.arid = id; ax.arvalid = 1;
        n = 0;
        while (n < TMO) begin @(negedge aclk); if (ax.arready) break; n++; end
        if (n >= TMO) begin check("ar_timeout", 0, 1); ax.arvalid = 0; return; end
        @(posedge aclk); #1;
        ax.arvalid = 0;
        check("rvalid_latency", ax.rvalid, 1);
        ok = 1;
    endtask

    // mode 0: rready held high, 1: toggles every cycle, 2: random.
    task automatic axi_read(input int unsigned addr, input int len, input int size, input int burst,
                            input logic [IW-1:0] id, input int mode, input logic [1:0] exp_resp);
        int            beat, n;
        bit            ok, stalled;
        logic [DW-1:0] prev, exp;
        for (int i = 0; i <= len; i++) exp_q.push_back(model_rd(beat_addr(addr, len, size, burst, i)));
        ar_issue(addr, len, size, burst, id, ok);
        if (!ok) begin exp_q.delete(); return; end
        ax.rready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        beat = 0; n = 0; stalled = 0; prev = '0;
        while (beat <= len && n < TMO) begin
            @(negedge aclk);
            if (stalled) begin
                check("r_hold_valid", ax.rvalid, 1);
                check("r_hold_data", ax.rdata, prev);
            end
            if (ax.rvalid && ax.rready) begin
                exp = exp_q.pop_front();
                check("rdata", ax.rdata, exp);
                check("rlast", ax.rlast, beat == len);
                check("rid", ax.rid, id);
                check("rresp", ax.rresp, exp_resp);
                last_rdata = ax.rdata;
                beat++;
            end
            stalled = ax.rvalid && !ax.rready;
            prev = ax.rdata;
            @(posedge aclk); #1;
            n++;
            if (mode == 1) ax.rready = ~ax.rready;
            else if (mode == 2) ax.rready = 1'($urandom_range(0, 1));
        end
        ax.rready = 0;
        if (beat <= len) begin check("r_timeout", 0, 1); exp_q.delete(); end
        else check("arready_after_r", ax.arready, 1);
    endtask

    task automatic fill_data(input int len, input bit full_strb);
        for (int i = 0; i <= len; i++) begin
            wd[i] = DW'($urandom());
            ws[i] = full_strb ? '1 : STRB'($urandom_range(0, (1 << STRB) - 1));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int unsigned addr;
        int len, size, burst, mode;
        bit ok;

        idle_bus();
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_awready", ax.awready, 0);
        check("rst_arready", ax.arready, 0);
        check("rst_wready", ax.wready, 0);
        check("rst_bvalid", ax.bvalid, 0);
        check("rst_rvalid", ax.rvalid, 0);
        check("rst_rlast", ax.rlast, 0);
        check("rst_bresp", ax.bresp, 0);
        check("rst_rresp", ax.rresp, 0);
        check("rst_bid", ax.bid, 0);
        check("rst_rid", ax.rid, 0);
        check("rst_rdata", ax.rdata, 0);
        check("rst_busy", busy, 0);
        aresetn = 1;
        @(posedge aclk); #1;
        check("awready_post_rst", ax.awready, 1);
        check("arready_post_rst", ax.arready, 1);

        // Known contents everywhere so every later read has a defined model value.
        for (int k = 0; k < DEPTH / 256; k++) begin
            fill_data(255, 1);
            axi_write(k * 256 * STRB, 255, 2, 1, 2'd0, -1, RESP_OKAY);
        end

        // 1: INCR 4 beats of 1..4
        for (int i = 0; i < 4; i++) begin wd[i] = DW'(i + 1); ws[i] = '1; end
        axi_write(32'h100, 3, 2, 1, 2'd1, -1, RESP_OKAY);
        axi_read(32'h100, 3, 2, 1, 2'd2, 0, RESP_OKAY);
        check("t1_last_beat", last_rdata, 4);

        // 2: WRAP len=3 starting mid-window
        fill_data(3, 1);
        axi_write(32'h108, 3, 2, 2, 2'd3, -1, RESP_OKAY);
        axi_read(32'h108, 3, 2, 2, 2'd0, 0, RESP_OKAY);
        axi_read(32'h100, 3, 2, 1, 2'd1, 0, RESP_OKAY);
        check("t2_word_10c", last_rdata, wd[1]);

        // 3: FIXED keeps hitting one word; last beat wins
        wd[0] = 32'hA; wd[1] = 32'hB; wd[2] = 32'hC; wd[3] = 32'hD;
        for (int i = 0; i < 4; i++) ws[i] = '1;
        axi_write(32'h20, 3, 2, 0, 2'd2, -1, RESP_OKAY);
        axi_read(32'h20, 0, 2, 1, 2'd2, 0, RESP_OKAY);
        check("t3_fixed_d", last_rdata, 32'hD);

        // 4: partial strobes over a saturated word
        wd[0] = 32'hFFFF_FFFF; ws[0] = '1;
        axi_write(32'h200, 0, 2, 1, 2'd0, -1, RESP_OKAY);
        wd[0] = 32'h1122_3344; ws[0] = 4'b0101;
        axi_write(32'h200, 0, 2, 1, 2'd0, -1, RESP_OKAY);
        axi_read(32'h200, 0, 2, 1, 2'd0, 0, RESP_OKAY);
        check("t4_strobe", last_rdata, 32'hFF22_FF44);

        // 5: rready toggling on an 8-beat read
        fill_data(7, 1);
        axi_write(32'h300, 7, 2, 1, 2'd1, -1, RESP_OKAY);
        axi_read(32'h300, 7, 2, 1, 2'd1, 1, RESP_OKAY);

        // Concurrent write and read on disjoint regions
        fill_data(15, 0);
        fork
            axi_write(32'h800, 15, 2, 1, 2'd2, -1, RESP_OKAY);
            axi_read(32'hC00, 15, 2, 1, 2'd3, 2, RESP_OKAY);
        join
        axi_read(32'h800, 15, 2, 1, 2'd0, 2, RESP_OKAY);

        // 6: reset in the middle of a 16-beat write with a stalled read open
        ar_issue(32'h40, 3, 2, 1, 2'd1, ok);
        fill_data(15, 1);
        axi_write(32'h400, 15, 2, 1, 2'd3, 6, RESP_OKAY);
        check("busy_mid_burst", busy, 1);
        #3;
        aresetn = 0;
        #1;
        check("rst_mid_bvalid", ax.bvalid, 0);
        check("rst_mid_rvalid", ax.rvalid, 0);
        check("rst_mid_wready", ax.wready, 0);
        check("rst_mid_busy", busy, 0);
        idle_bus();
        @(negedge aclk);
        aresetn = 1;
        @(posedge aclk); #1;
        axi_read(32'h400, 15, 2, 1, 2'd2, 0, RESP_OKAY);
        fill_data(15, 1);
        axi_write(32'h400, 15, 2, 1, 2'd1, -1, RESP_OKAY);
        axi_read(32'h400, 15, 2, 1, 2'd1, 2, RESP_OKAY);

`ifdef AXI_RAM_ERR_EN
        wd[0] = 32'h5A5A_5A5A; ws[0] = '1;
        axi_write(DEPTH * STRB, 0, 2, 1, 2'd0, -1, RESP_SLVERR);
        axi_read(DEPTH * STRB, 0, 2, 1, 2'd0, 0, RESP_SLVERR);
`endif

        // Randomized bursts, kept inside the array so both builds agree.
        for (int t = 0; t < 40; t++) begin
            burst = $urandom_range(0, 2);
            size  = $urandom_range(0, 2);
            if (burst == 2) begin
                len  = (2 << $urandom_range(0, 3)) - 1;
                addr = $urandom_range(0, DEPTH * STRB - 1) & ~((32'd1 << size) - 1);
            end else if (burst == 1) begin
                len  = $urandom_range(0, 15);
                addr = $urandom_range(0, DEPTH * STRB - 1 - (len + 1) * STRB);
            end else begin
                len  = $urandom_range(0, 7);
                addr = $urandom_range(0, DEPTH * STRB - 1);
            end
            mode = $urandom_range(0, 2);
            fill_data(len, 0);
            axi_write(addr, len, size, burst, IW'($urandom_range(0, 3)), -1, RESP_OKAY);
            axi_read(addr, len, size, burst, IW'($urandom_range(0, 3)), mode, RESP_OKAY);
            addr = $urandom_range(0, DEPTH * STRB - 1 - 16 * STRB) & ~(STRB - 1);
            axi_read(addr, $urandom_range(0, 15), 2, 1, IW'($urandom_range(0, 3)), mode, RESP_OKAY);
        end

        repeat (2) @(posedge aclk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
